pipe_stage_skid: RTL and testbench

//  Parametrised inter-stage pipeline register for the MIPS core (ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid_pkg.sv | 48 ++++
 rtl/pipe_stage_skid_if.sv | 17 +
 rtl/pipe_stage_skid_slot.sv | 44 ++++
 rtl/pipe_stage_skid.sv | 156 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for the MIPS inter-stage pipeline registers.
// Holds the ID/EX control bundle layout, the bubble encoding and the slot-steering enum.
package pipe_stage_skid_pkg;

   localparam int unsigned IDEX_DATA_W = 128;

   localparam int unsigned ALU_CTRL_W = 6;
   localparam int unsigned MEM_OP_W   = 3;

   typedef struct packed {
      logic [ALU_CTRL_W-1:0] alu_control;
      logic [MEM_OP_W-1:0]   mem_op;
      logic                  alu_src;
      logic                  reg_write;
      logic                  mem_to_reg;
      logic                  mem_write;
      logic                  reg_dst;
      logic                  halt;
   } idex_ctrl_t;

   localparam int unsigned IDEX_CTRL_W = $bits(idex_ctrl_t);

   // Bit offsets of each field inside the flattened control vector
   localparam int unsigned HALT_OFS       = 0;
   localparam int unsigned REG_DST_OFS    = 1;
   localparam int unsigned MEM_WRITE_OFS  = 2;
   localparam int unsigned MEM_TO_REG_OFS = 3;
   localparam int unsigned REG_WRITE_OFS  = 4;
   localparam int unsigned ALU_SRC_OFS    = 5;
   localparam int unsigned MEM_OP_OFS     = 6;
   localparam int unsigned ALU_CTRL_OFS   = MEM_OP_OFS + MEM_OP_W;

   localparam idex_ctrl_t CTRL_BUBBLE = '0;

   typedef enum logic [2:0] {
      STEER_HOLD,
      STEER_IN_TO_M,
      STEER_IN_TO_S,
      STEER_S_TO_M,
      STEER_DRAIN,
      STEER_FLUSH
   } steer_e;

   function automatic logic [1:0] occ_count(input logic m_valid, input logic s_valid);
      return {1'b0, m_valid} + {1'b0, s_valid};
   endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready beat bus carrying a data payload and a decoded control bundle.
interface pipe_stage_skid_if
   import pipe_stage_skid_pkg::*;
#(
   parameter int unsigned DATA_W = IDEX_DATA_W,
   parameter int unsigned CTRL_W = IDEX_CTRL_W
) ();

   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   modport master (output valid, output data, output ctrl, input ready);
   modport slave  (input valid, input data, input ctrl, output ready);

endinterface

// File: rtl/pipe_stage_skid_slot.sv
// One pipeline entry: valid flag, data and control with load and clear-to-bubble.
// Clearing drops valid and forces the bubble control but leaves data untouched.
module pipe_slot
   import pipe_stage_skid_pkg::*;
#(
   parameter int unsigned       DATA_W = IDEX_DATA_W,
   parameter int unsigned       CTRL_W = IDEX_CTRL_W,
   parameter logic [CTRL_W-1:0] BUBBLE = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CTRL_W-1:0] i_ctrl,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic [CTRL_W-1:0] o_ctrl
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [CTRL_W-1:0] r_ctrl;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ctrl  <= BUBBLE;
      end else if (i_clear) begin
         r_valid <= 1'b0;
         r_ctrl  <= BUBBLE;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_ctrl  <= i_ctrl;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble and optional skid slot.
// M drives the outputs; S catches the beat accepted while M is stalled so in_ready can be registered.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int unsigned DATA_W = IDEX_DATA_W,
   parameter int unsigned CTRL_W = IDEX_CTRL_W,
   parameter bit          SKID   = 1'b1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   pipe_stage_skid_if.slave  in_bus,
   pipe_stage_skid_if.master out_bus,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CTRL_W-1:0] W_BUBBLE = CTRL_W'(CTRL_BUBBLE);

   steer_e            w_steer;
   logic              w_acc;
   logic              w_deq;
   logic              w_in_ready;
   logic              w_m_load;
   logic              w_m_clear;
   logic              w_m_src_s;
   logic              w_s_load;
   logic              w_s_clear;
   logic              w_m_valid;
   logic              w_s_valid;
   logic              w_m_valid_nxt;
   logic              w_s_valid_nxt;
   logic [DATA_W-1:0] w_m_data;
   logic [CTRL_W-1:0] w_m_ctrl;
   logic [DATA_W-1:0] w_s_data;
   logic [CTRL_W-1:0] w_s_ctrl;
   logic [DATA_W-1:0] w_m_din;
   logic [CTRL_W-1:0] w_m_cin;

   logic              r_in_ready;
   logic [1:0]        r_occ;
   logic [CNT_W-1:0]  r_stall_cnt;

   assign w_acc = in_bus.valid & w_in_ready;
   assign w_deq = w_m_valid & out_bus.ready;

   // Flush wins over every load; a held S beat always refills M before new input
   always_comb begin
      w_steer = STEER_HOLD;
      if (flush) begin
         w_steer = STEER_FLUSH;
      end else if (!w_m_valid) begin
         if (w_acc) w_steer = STEER_IN_TO_M;
      end else if (w_deq) begin
         if (w_s_valid)  w_steer = STEER_S_TO_M;
         else if (w_acc) w_steer = STEER_IN_TO_M;
         else            w_steer = STEER_DRAIN;
      end else if (w_acc) begin
         w_steer = STEER_IN_TO_S;
      end
   end

   always_comb begin
      w_m_load  = 1'b0;
      w_m_clear = 1'b0;
      w_m_src_s = 1'b0;
      w_s_load  = 1'b0;
      w_s_clear = 1'b0;
      case (w_steer)
         STEER_IN_TO_M: w_m_load = 1'b1;
         STEER_IN_TO_S: w_s_load = 1'b1;
         STEER_S_TO_M: begin
            w_m_load  = 1'b1;
            w_m_src_s = 1'b1;
            w_s_clear = 1'b1;
         end
         STEER_DRAIN:   w_m_clear = 1'b1;
         STEER_FLUSH: begin
            w_m_clear = 1'b1;
            w_s_clear = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_m_din       = w_m_src_s ? w_s_data : in_bus.data;
   assign w_m_cin       = w_m_src_s ? w_s_ctrl : in_bus.ctrl;
   assign w_m_valid_nxt = w_m_load | (w_m_valid & ~w_m_clear);
   assign w_s_valid_nxt = w_s_load | (w_s_valid & ~w_s_clear);

   pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W),
      .BUBBLE (W_BUBBLE)
   ) u_m (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_m_load),
      .i_clear (w_m_clear),
      .i_data  (w_m_din),
      .i_ctrl  (w_m_cin),
      .o_valid (w_m_valid),
      .o_data  (w_m_data),
      .o_ctrl  (w_m_ctrl)
   );

   generate
      if (SKID) begin : g_skid
         pipe_slot #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W),
            .BUBBLE (W_BUBBLE)
         ) u_s (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_s_load),
            .i_clear (w_s_clear),
            .i_data  (in_bus.data),
            .i_ctrl  (in_bus.ctrl),
            .o_valid (w_s_valid),
            .o_data  (w_s_data),
            .o_ctrl  (w_s_ctrl)
         );
         assign w_in_ready = r_in_ready;
      end else begin : g_noskid
         assign w_s_valid  = 1'b0;
         assign w_s_data   = '0;
         assign w_s_ctrl   = '0;
         // r_in_ready only marks "out of reset" here; readiness tracks out_ready directly
         assign w_in_ready = r_in_ready & (~w_m_valid | out_bus.ready);
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_in_ready  <= 1'b0;
         r_occ       <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_in_ready <= SKID ? ~w_s_valid_nxt : 1'b1;
         r_occ      <= occ_count(w_m_valid_nxt, w_s_valid_nxt);
         if (w_m_valid && !out_bus.ready && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign in_bus.ready  = w_in_ready;
   assign out_bus.valid = w_m_valid;
   assign out_bus.data  = w_m_data;
   assign out_bus.ctrl  = w_m_ctrl;
   assign occupancy     = r_occ;
   assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance behind a shared driver.
module tb_pipe_stage_skid;
   import pipe_stage_skid_pkg::*;

   localparam int unsigned DW = 16;
   localparam int unsigned CW = IDEX_CTRL_W;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          flush = 1'b0;
   logic          sel = 1'b0;
   logic          d_valid = 1'b0;
   logic [DW-1:0] d_data = '0;
   logic          d_oready = 1'b1;

   int checks = 0;
   int fails = 0;
   int cyc = 0;
   int deq_cnt = 0;
   int first_deq = 0;
   int last_deq = 0;
   int max_occ = 0;
   logic [CW+DW-1:0] sb[$];
   logic [CW+DW-1:0] exp_beat;

   pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) a_in ();
   pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) a_out ();
   pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) b_in ();
   pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) b_out ();

   logic [1:0]  a_occ, b_occ;
   logic [15:0] a_scnt, b_scnt;

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CNT_W(16)) u_skid (
      .clk(clk), .reset(reset), .flush(flush), .in_bus(a_in), .out_bus(a_out),
      .occupancy(a_occ), .stall_cnt(a_scnt));

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .CNT_W(16)) u_noskid (
      .clk(clk), .reset(reset), .flush(flush), .in_bus(b_in), .out_bus(b_out),
      .occupancy(b_occ), .stall_cnt(b_scnt));

   function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
      return CW'({d, 1'b1});
   endfunction

   assign a_in.valid  = d_valid & ~sel;
   assign a_in.data   = d_data;
   assign a_in.ctrl   = ctrl_of(d_data);
   assign a_out.ready = sel ? 1'b1 : d_oready;
   assign b_in.valid  = d_valid & sel;
   assign b_in.data   = d_data;
   assign b_in.ctrl   = ctrl_of(d_data);
   assign b_out.ready = sel ? d_oready : 1'b1;

   wire          w_ovalid = sel ? b_out.valid : a_out.valid;
   wire [DW-1:0] w_odata  = sel ? b_out.data  : a_out.data;
   wire [CW-1:0] w_octrl  = sel ? b_out.ctrl  : a_out.ctrl;
   wire          w_irdy   = sel ? b_in.ready  : a_in.ready;
   wire [1:0]    w_occ    = sel ? b_occ       : a_occ;
   wire [15:0]   w_scnt   = sel ? b_scnt      : a_scnt;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Mid-cycle monitor: handshakes seen here complete on the following rising edge
   always @(negedge clk) begin
      if (reset) begin
         if (int'(w_occ) > max_occ) max_occ = int'(w_occ);
         if (!w_ovalid) begin
            checks++;
            if (w_octrl !== '0) begin
               fails++;
               $display("FAIL bubble_ctrl: out_ctrl=%h required 0", w_octrl);
            end
         end else if (d_oready) begin
            checks++;
            deq_cnt++;
            if (deq_cnt == 1) first_deq = cyc;
            last_deq = cyc;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL sb_unexpected: out_data=%h with no expected beat", w_odata);
            end else begin
               exp_beat = sb.pop_front();
               if ({w_octrl, w_odata} !== exp_beat) begin
                  fails++;
                  $display("FAIL sb_beat: got ctrl=%h data=%h required ctrl=%h data=%h",
                           w_octrl, w_odata, exp_beat[CW+DW-1:DW], exp_beat[DW-1:0]);
               end
            end
         end
         if (flush) sb.delete();
         else if (d_valid && w_irdy) sb.push_back({ctrl_of(d_data), d_data});
      end
   end

   task automatic send_beat(input logic [DW-1:0] v);
      bit took = 1'b0;
      int n = 0;
      d_valid = 1'b1;
      d_data  = v;
      while (!took && n < 200) begin
         @(negedge clk);
         took = w_irdy;
         @(posedge clk); #1;
         n++;
      end
      d_valid = 1'b0;
      if (!took) begin
         checks++; fails++;
         $display("FAIL send_timeout: beat %h not accepted within 200 cycles", v);
      end
   endtask

   task automatic wait_deq(input int target, input int budget);
      int n = 0;
      while (deq_cnt < target && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (deq_cnt < target) begin
         fails++;
         $display("FAIL wait_deq: delivered %0d required %0d", deq_cnt, target);
      end
   endtask

   task automatic test_reset_init();
      #3;
      checks++;
      if (a_out.valid !== 1'b0 || b_out.valid !== 1'b0 || a_out.ctrl !== '0 || b_out.ctrl !== '0 ||
          a_out.data !== '0 || a_occ !== 2'd0 || b_occ !== 2'd0 || a_scnt !== '0 || b_scnt !== '0) begin
         fails++;
         $display("FAIL reset_state: valid=%b/%b ctrl=%h/%h occ=%0d/%0d scnt=%0d/%0d required all 0",
                  a_out.valid, b_out.valid, a_out.ctrl, b_out.ctrl, a_occ, b_occ, a_scnt, b_scnt);
      end
      #20;
      checks++;
      if (a_in.ready !== 1'b0 || b_in.ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_ready_held: in_ready=%b/%b required 0/0", a_in.ready, b_in.ready);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (a_in.ready !== 1'b0 || b_in.ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_ready_release: in_ready=%b/%b required 0/0", a_in.ready, b_in.ready);
      end
      @(posedge clk); #1;
      checks++;
      if (a_in.ready !== 1'b1 || b_in.ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready_edge: in_ready=%b/%b required 1/1", a_in.ready, b_in.ready);
      end
   endtask

   task automatic test_streaming(input logic sel_v);
      int acc_n = 0;
      int iters = 0;
      bit took;
      sel = sel_v; d_oready = 1'b1; deq_cnt = 0;
      d_valid = 1'b1; d_data = 16'd1;
      while (acc_n < 100 && iters < 400) begin
         @(negedge clk);
         took = w_irdy;
         if (acc_n == 1 && iters == 1) begin
            checks++;
            if (!(w_ovalid === 1'b1 && w_odata === 16'd1)) begin
               fails++;
               $display("FAIL stream_latency: valid=%b data=%h required 1/0001", w_ovalid, w_odata);
            end
         end
         @(posedge clk); #1;
         iters++;
         if (took) begin
            acc_n++;
            d_data = DW'(acc_n + 1);
         end
      end
      d_valid = 1'b0;
      checks++;
      if (iters != 100) begin
         fails++;
         $display("FAIL stream_accept_rate: cycles=%0d required 100", iters);
      end
      wait_deq(100, 50);
      checks++;
      if (last_deq - first_deq != 99) begin
         fails++;
         $display("FAIL stream_out_rate: span=%0d required 99", last_deq - first_deq);
      end
      checks++;
      if (w_scnt !== 16'd0) begin
         fails++;
         $display("FAIL stream_stall_cnt: stall_cnt=%0d required 0", w_scnt);
      end
   endtask

   task automatic test_stall_fill(input logic sel_v);
      logic [1:0] full_occ;
      sel = sel_v; d_oready = 1'b0; deq_cnt = 0; max_occ = 0;
      full_occ = sel_v ? 2'd1 : 2'd2;
      fork
         begin
            send_beat(16'h00A0);
            send_beat(16'h00B0);
            send_beat(16'h00C0);
         end
         begin
            int n = 0;
            while (w_occ != full_occ && n < 20) begin
               @(negedge clk);
               n++;
            end
            repeat (3) begin
               @(negedge clk);
               checks++;
               if (w_occ !== full_occ || w_irdy !== 1'b0 || w_ovalid !== 1'b1 || w_odata !== 16'h00A0) begin
                  fails++;
                  $display("FAIL stall_hold: occ=%0d in_ready=%b valid=%b data=%h required %0d/0/1/00a0",
                           w_occ, w_irdy, w_ovalid, w_odata, full_occ);
               end
            end
            @(posedge clk); #1;
            d_oready = 1'b1;
            #1;
            checks++;
            if (w_irdy !== sel_v) begin
               fails++;
               $display("FAIL stall_ready_path: in_ready=%b required %b", w_irdy, sel_v);
            end
            wait_deq(3, 20);
            checks++;
            if (last_deq - first_deq != 2) begin
               fails++;
               $display("FAIL stall_release_rate: span=%0d required 2", last_deq - first_deq);
            end
         end
      join
      checks++;
      if (max_occ != int'(full_occ)) begin
         fails++;
         $display("FAIL stall_max_occ: max occupancy=%0d required %0d", max_occ, full_occ);
      end
   endtask

   task automatic test_flush(input logic sel_v);
      sel = sel_v; d_oready = 1'b0; deq_cnt = 0;
      if (!sel_v) begin
         d_valid = 1'b1; d_data = 16'h0011;
         @(posedge clk); #1;
         d_data = 16'h0022;
         @(posedge clk); #1;
         d_data = 16'h0033; flush = 1'b1; d_oready = 1'b1;
         @(negedge clk);
         checks++;
         if (w_occ !== 2'd2) begin
            fails++;
            $display("FAIL flush_full_pre: occ=%0d required 2", w_occ);
         end
         @(posedge clk); #1;
         flush = 1'b0; d_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (w_ovalid !== 1'b0 || w_octrl !== '0 || w_occ !== 2'd0 || w_odata !== 16'h0011 || deq_cnt != 1) begin
            fails++;
            $display("FAIL flush_full: valid=%b ctrl=%h occ=%0d data=%h delivered=%0d required 0/0/0/0011/1",
                     w_ovalid, w_octrl, w_occ, w_odata, deq_cnt);
         end
         @(posedge clk); #1;
         d_oready = 1'b0;
      end
      d_valid = 1'b1; d_data = 16'h0044;
      @(posedge clk); #1;
      d_data = 16'h0055; flush = 1'b1; d_oready = 1'b1;
      @(negedge clk);
      checks++;
      if (w_irdy !== 1'b1) begin
         fails++;
         $display("FAIL flush_acc_ready: in_ready=%b required 1", w_irdy);
      end
      @(posedge clk); #1;
      flush = 1'b0; d_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (w_ovalid !== 1'b0 || w_octrl !== '0 || w_occ !== 2'd0 || w_odata !== 16'h0044) begin
         fails++;
         $display("FAIL flush_acc: valid=%b ctrl=%h occ=%0d data=%h required 0/0/0/0044",
                  w_ovalid, w_octrl, w_occ, w_odata);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (deq_cnt != (sel_v ? 1 : 2) || sb.size() != 0) begin
         fails++;
         $display("FAIL flush_lost_beat: delivered=%0d pending=%0d required %0d/0",
                  deq_cnt, sb.size(), sel_v ? 1 : 2);
      end
   endtask

   task automatic test_reset_midstream();
      sel = 1'b0; d_oready = 1'b0;
      send_beat(16'h0066);
      send_beat(16'h0067);
      @(negedge clk);
      checks++;
      if (a_occ !== 2'd2) begin
         fails++;
         $display("FAIL midreset_pre: occ=%0d required 2", a_occ);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (a_out.valid !== 1'b0 || a_out.ctrl !== '0 || a_occ !== 2'd0 || a_in.ready !== 1'b0 || a_scnt !== '0) begin
         fails++;
         $display("FAIL midreset_async: valid=%b ctrl=%h occ=%0d in_ready=%b scnt=%0d required 0/0/0/0/0",
                  a_out.valid, a_out.ctrl, a_occ, a_in.ready, a_scnt);
      end
      sb.delete();
      d_oready = 1'b1;
      @(posedge clk); @(posedge clk); #3;
      checks++;
      if (a_in.ready !== 1'b0 || b_in.ready !== 1'b0) begin
         fails++;
         $display("FAIL midreset_held: in_ready=%b/%b required 0/0", a_in.ready, b_in.ready);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (a_in.ready !== 1'b0) begin
         fails++;
         $display("FAIL midreset_release: in_ready=%b required 0", a_in.ready);
      end
      @(posedge clk); #1;
      checks++;
      if (a_in.ready !== 1'b1 || b_in.ready !== 1'b1) begin
         fails++;
         $display("FAIL midreset_edge: in_ready=%b/%b required 1/1", a_in.ready, b_in.ready);
      end
   endtask

   task automatic test_stall_counter();
      sel = 1'b0; d_oready = 1'b0; deq_cnt = 0;
      send_beat(16'h0077);
      @(negedge clk);
      checks++;
      if (a_scnt !== 16'd0 || a_out.valid !== 1'b1) begin
         fails++;
         $display("FAIL stallcnt_start: stall_cnt=%0d valid=%b required 0/1", a_scnt, a_out.valid);
      end
      repeat (100) @(negedge clk);
      checks++;
      if (a_scnt !== 16'd100) begin
         fails++;
         $display("FAIL stallcnt_count: stall_cnt=%0d required 100", a_scnt);
      end
      repeat (69900) @(negedge clk);
      checks++;
      if (a_scnt !== 16'hFFFF) begin
         fails++;
         $display("FAIL stallcnt_saturate: stall_cnt=%0d required 65535", a_scnt);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (a_scnt !== 16'hFFFF) begin
         fails++;
         $display("FAIL stallcnt_nowrap: stall_cnt=%0d required 65535", a_scnt);
      end
      @(posedge clk); #1;
      d_oready = 1'b1;
      wait_deq(1, 10);
   endtask

   initial begin
      test_reset_init();
      test_streaming(1'b0);
      test_stall_fill(1'b0);
      test_flush(1'b0);
      test_flush(1'b1);
      test_reset_midstream();
      test_streaming(1'b1);
      test_stall_fill(1'b1);
      test_stall_counter();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
